e203_reset_req_gen: RTL and testbench

//  Reset-request generator: the source side of the reset-controller rst_n input.

---
 rtl/e203_reset_req_gen_pkg.sv | 21 ++
 rtl/e203_reset_req_gen_if.sv | 39 +++
 rtl/e203_rst_fb_sync.sv | 22 ++
 rtl/e203_reset_req_gen.sv | 115 +++++++++++
 tb/tb_e203_reset_req_gen.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/e203_reset_req_gen_pkg.sv
// Shared types for the reset-request generator.
// State encodings and default timing knobs.
package e203_reset_req_gen_pkg;

  localparam int E203_RST_REQ_HOLD_CYCLES = 16;
  localparam int E203_ASYNC_FF_LEVELS     = 2;

  typedef enum logic [1:0] {
    RST_ST_IDLE    = 2'd0,
    RST_ST_ASSERT  = 2'd1,
    RST_ST_HOLD    = 2'd2,
    RST_ST_RELEASE = 2'd3
  } rst_st_e;

  typedef struct packed {
    logic dbg;
    logic wdog;
    logic sw;
  } rst_src_t;

endpackage

// File: rtl/e203_reset_req_gen_if.sv
// Request/feedback bundle between reset sources,
// the request generator and the reset controller.
interface e203_reset_req_gen_if;

  logic       test_mode;
  logic       sw_rst_req;
  logic       wdog_rst_req;
  logic       dbg_rst_req;
  logic       rst_fb_n;
  logic       cause_clr;
  logic       rst_req_n;
  logic       rst_busy;
  logic [2:0] rst_cause;

  modport master (
    output test_mode,
    output sw_rst_req,
    output wdog_rst_req,
    output dbg_rst_req,
    output rst_fb_n,
    output cause_clr,
    input  rst_req_n,
    input  rst_busy,
    input  rst_cause
  );

  modport slave (
    input  test_mode,
    input  sw_rst_req,
    input  wdog_rst_req,
    input  dbg_rst_req,
    input  rst_fb_n,
    input  cause_clr,
    output rst_req_n,
    output rst_busy,
    output rst_cause
  );

endinterface

// File: rtl/e203_rst_fb_sync.sv
// Synchroniser for the rst_core feedback.
// Resets to 0 so a power-on reset reads as "in reset".
module e203_rst_fb_sync #(
  parameter int LEVELS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [LEVELS-1:0] ff;

  // shift the async feedback through LEVELS flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[LEVELS-2:0], d};
  end

  assign q = ff[LEVELS-1];

endmodule

// File: rtl/e203_reset_req_gen.sv
// Reset-request generator: merges sw/wdog/dbg requests.
// Optional sticky cause capture: E203_RST_CAUSE_EN.
module e203_reset_req_gen
  import e203_reset_req_gen_pkg::*;
#(
  parameter int HOLD_CYCLES = E203_RST_REQ_HOLD_CYCLES,
  parameter int CNT_W       = 5,
  parameter int SYNC_LEVELS = E203_ASYNC_FF_LEVELS
) (
  input logic                 clk,
  input logic                 rst_n,
  e203_reset_req_gen_if.slave rif
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(HOLD_CYCLES - 1);

  rst_st_e          state;
  logic [CNT_W-1:0] cnt;
  logic             sw_pend;
  logic             fb_s;
  logic             any_req;
  logic             lvl_req;
  logic             go;

  e203_rst_fb_sync #(
    .LEVELS (SYNC_LEVELS)
  ) u_fb_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rif.rst_fb_n),
    .q     (fb_s)
  );

  assign lvl_req = rif.wdog_rst_req | rif.dbg_rst_req;
  assign any_req = sw_pend | rif.sw_rst_req | lvl_req;
  assign go      = (state == RST_ST_IDLE) & any_req
                 & ~rif.test_mode;

  // request FSM with registered rst_req_n/rst_busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RST_ST_IDLE;
      cnt           <= '0;
      sw_pend       <= 1'b0;
      rif.rst_req_n <= 1'b1;
      rif.rst_busy  <= 1'b0;
    end else if (rif.test_mode) begin
      state         <= RST_ST_IDLE;
      sw_pend       <= 1'b0;
      rif.rst_req_n <= 1'b1;
      rif.rst_busy  <= 1'b0;
    end else begin
      unique case (state)
        RST_ST_IDLE: begin
          if (any_req) begin
            state         <= RST_ST_ASSERT;
            sw_pend       <= 1'b0;
            rif.rst_req_n <= 1'b0;
            rif.rst_busy  <= 1'b1;
          end
        end
        RST_ST_ASSERT: begin
          if (!fb_s) begin
            state <= RST_ST_HOLD;
            cnt   <= '0;
          end
        end
        RST_ST_HOLD: begin
          if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end else if (!lvl_req) begin
            state         <= RST_ST_RELEASE;
            rif.rst_req_n <= 1'b1;
          end
        end
        RST_ST_RELEASE: begin
          if (rif.sw_rst_req) sw_pend <= 1'b1;
          if (fb_s) begin
            state        <= RST_ST_IDLE;
            rif.rst_busy <= 1'b0;
          end
        end
        default: state <= RST_ST_IDLE;
      endcase
    end
  end

`ifdef E203_RST_CAUSE_EN
  rst_src_t cause_q;
  rst_src_t src;

  assign src.dbg  = rif.dbg_rst_req;
  assign src.wdog = rif.wdog_rst_req;
  assign src.sw   = sw_pend | rif.sw_rst_req;

  // sticky cause; a capture overrides a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q <= '0;
    end else if (go) begin
      cause_q <= (rif.cause_clr ? '0 : cause_q) | src;
    end else if (rif.cause_clr) begin
      cause_q <= '0;
    end
  end

  assign rif.rst_cause = cause_q;
`else
  logic unused_cause;
  assign unused_cause  = rif.cause_clr ^ go;
  assign rif.rst_cause = 3'b000;
`endif

endmodule

// File: tb/tb_e203_reset_req_gen.sv
// Directed bench for e203_reset_req_gen.
// Feedback loop models a 3-cycle reset controller.
module tb_e203_reset_req_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sh = 3'b111;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         lo, bz, n;

  e203_reset_req_gen_if rif();

  e203_reset_req_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rif   (rif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sh <= {sh[1:0], rif.rst_req_n};
  assign rif.rst_fb_n = sh[2];

  function automatic logic [2:0] expc(input logic [2:0] v);
`ifdef E203_RST_CAUSE_EN
    return v;
`else
    return 3'b000 & v;
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic meas(input int inj, output int l, output int b);
    l = 0;
    b = 0;
    for (int i = 0; i < 200; i++) begin
      if (!rif.rst_req_n) l++;
      if (!rif.rst_busy) break;
      b++;
      rif.sw_rst_req = (i == inj);
      tick();
    end
    rif.sw_rst_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (rif.rst_busy && k < 100) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, rif.rst_busy}, 32'd0);
    repeat (6) tick();
  endtask

  task automatic quiet(input string tag, input int len);
    int c;
    c = 0;
    repeat (len) begin
      tick();
      if (rif.rst_busy || !rif.rst_req_n) c++;
    end
    chk(tag, c, 0);
  endtask

  task automatic sw_pulse();
    rif.sw_rst_req = 1'b1;
    tick();
    rif.sw_rst_req = 1'b0;
  endtask

  initial begin
    rif.test_mode    = 1'b0;
    rif.sw_rst_req   = 1'b0;
    rif.wdog_rst_req = 1'b0;
    rif.dbg_rst_req  = 1'b0;
    rif.cause_clr    = 1'b0;
    tick();
    chk("rst_req_n", {31'd0, rif.rst_req_n}, 32'd1);
    chk("rst_busy", {31'd0, rif.rst_busy}, 32'd0);
    chk("rst_cause", {29'd0, rif.rst_cause}, 32'd0);
    tick();
    rst_n = 1'b1;
    while (cyc < 10) tick();

    // 1: sw pulse, full sequence timing
    sw_pulse();
    chk("t1_lat", {31'd0, rif.rst_req_n}, 32'd0);
    chk("t1_busy", {31'd0, rif.rst_busy}, 32'd1);
    meas(-1, lo, bz);
    chk("t1_low", lo, 22);
    chk("t1_bsy", bz, 28);
    chk("t1_cause", {29'd0, rif.rst_cause}, {29'd0, expc(3'b001)});
    repeat (6) tick();

    // 3a: sw pulse in HOLD is absorbed
    sw_pulse();
    meas(10, lo, bz);
    chk("t3a_low", lo, 22);
    chk("t3a_bsy", bz, 28);
    quiet("t3a_none", 30);

    // 3b: sw pulse in RELEASE gives a second sequence
    sw_pulse();
    meas(23, lo, bz);
    chk("t3b_bsy", bz, 28);
    tick();
    chk("t3b_2nd", {31'd0, rif.rst_req_n}, 32'd0);
    meas(-1, lo, bz);
    chk("t3b_low2", lo, 22);
    chk("t3b_bsy2", bz, 28);
    quiet("t3b_none", 30);

    // 2: watchdog level held 40 cycles
    rif.cause_clr = 1'b1;
    tick();
    rif.cause_clr = 1'b0;
    rif.wdog_rst_req = 1'b1;
    tick();
    chk("t2_lat", {31'd0, rif.rst_req_n}, 32'd0);
    repeat (39) tick();
    rif.wdog_rst_req = 1'b0;
    chk("t2_hold", {31'd0, rif.rst_req_n}, 32'd0);
    tick();
    chk("t2_rel", {31'd0, rif.rst_req_n}, 32'd1);
    chk("t2_cause", {29'd0, rif.rst_cause}, {29'd0, expc(3'b010)});
    wait_idle("t2_idle");

    // 4: test_mode suppresses requests and aborts HOLD
    rif.test_mode = 1'b1;
    rif.dbg_rst_req = 1'b1;
    n = 0;
    repeat (8) begin
      tick();
      if (!rif.rst_req_n || rif.rst_busy) n++;
    end
    chk("t4_supp", n, 0);
    rif.dbg_rst_req = 1'b0;
    rif.test_mode = 1'b0;
    tick();
    sw_pulse();
    repeat (10) tick();
    chk("t4_inhold", {31'd0, rif.rst_req_n}, 32'd0);
    rif.test_mode = 1'b1;
    tick();
    rif.test_mode = 1'b0;
    chk("t4_req", {31'd0, rif.rst_req_n}, 32'd1);
    chk("t4_busy", {31'd0, rif.rst_busy}, 32'd0);
    quiet("t4_none", 12);

    // 5: power-on reset during HOLD
    sw_pulse();
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("t5_req", {31'd0, rif.rst_req_n}, 32'd1);
    chk("t5_busy", {31'd0, rif.rst_busy}, 32'd0);
    chk("t5_cause", {29'd0, rif.rst_cause}, 32'd0);
    tick();
    rst_n = 1'b1;
    quiet("t5_none", 20);

    // 6: cause capture, then clear colliding with capture
    rif.sw_rst_req = 1'b1;
    rif.dbg_rst_req = 1'b1;
    tick();
    rif.sw_rst_req = 1'b0;
    chk("t6_cause1", {29'd0, rif.rst_cause}, {29'd0, expc(3'b101)});
    repeat (3) tick();
    rif.dbg_rst_req = 1'b0;
    wait_idle("t6_idle1");
    rif.cause_clr = 1'b1;
    rif.wdog_rst_req = 1'b1;
    tick();
    rif.cause_clr = 1'b0;
    chk("t6_cause2", {29'd0, rif.rst_cause}, {29'd0, expc(3'b010)});
    rif.wdog_rst_req = 1'b0;
    wait_idle("t6_idle2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
